decode_stage: RTL and testbench

- Pipeline stage directly downstream of the fetch stage, RV32I subset.
- Consumes the fetched instruction, its PC and the valid (ce) strobe.
- Decodes register addresses, immediate and ALU operation into a registered ID/EX pipeline register.
- Detects load-use hazards, inserts bubbles, and propagates stall/flush between execute and fetch.

---
 rtl/decode_stage.sv | 190 +++++++++++++++++++
 tb/tb_decode_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: registers decoded fields into the ID/EX register, detects load-use hazards and forwards stall/flush.
// Optional build macro DECODE_ILLEGAL_EN enables illegal-instruction flagging on ds_o_illegal.
module decode_stage #(
  parameter int IWIDTH     = 32,
  parameter int PC_WIDTH   = 32,
  parameter int REG_AWIDTH = 5,
  parameter int ALU_WIDTH  = 4
) (
  input  logic                  ds_clk,
  input  logic                  ds_rst,
  input  logic [IWIDTH-1:0]     ds_i_instr,
  input  logic [PC_WIDTH-1:0]   ds_i_pc,
  input  logic                  ds_i_ce,
  input  logic                  ds_i_stall,
  input  logic                  ds_i_flush,
  output logic                  ds_o_stall,
  output logic                  ds_o_flush,
  output logic                  ds_o_ce,
  output logic [PC_WIDTH-1:0]   ds_o_pc,
  output logic [REG_AWIDTH-1:0] ds_o_rs1_addr,
  output logic [REG_AWIDTH-1:0] ds_o_rs2_addr,
  output logic [REG_AWIDTH-1:0] ds_o_rd_addr,
  output logic [31:0]           ds_o_imm,
  output logic [6:0]            ds_o_opcode,
  output logic [2:0]            ds_o_funct3,
  output logic [ALU_WIDTH-1:0]  ds_o_alu_op,
  output logic                  ds_o_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [ALU_WIDTH-1:0] ALU_ADD = 4'd0;

  // Handshake: ds_i_ce qualifies instr/pc; the stage accepts on an edge with no flush, stall or hazard.
  // ds_o_ce qualifies every registered field; ds_o_stall tells fetch to hold its current instruction.

  logic [6:0]            op;
  logic [2:0]            f3;
  logic [REG_AWIDTH-1:0] d_rs1, d_rs2, d_rd;
  logic [31:0]           d_imm;
  logic [ALU_WIDTH-1:0]  d_alu;
  logic                  use_rs1, use_rs2, hazard;

  assign op = ds_i_instr[6:0];
  assign f3 = ds_i_instr[14:12];

  function automatic logic [ALU_WIDTH-1:0] alu_fn(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  alu_fn = alt ? 4'd1 : 4'd0;
      3'b001:  alu_fn = 4'd2;
      3'b010:  alu_fn = 4'd3;
      3'b011:  alu_fn = 4'd4;
      3'b100:  alu_fn = 4'd5;
      3'b101:  alu_fn = alt ? 4'd7 : 4'd6;
      3'b110:  alu_fn = 4'd8;
      default: alu_fn = 4'd9;
    endcase
  endfunction

`ifdef DECODE_ILLEGAL_EN
  logic d_illegal;

  function automatic logic is_illegal(input logic [31:0] ins);
    logic [2:0] fn;
    fn = ins[14:12];
    case (ins[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM: is_illegal = 1'b0;
      OP_LOAD:   is_illegal = (fn == 3'b011) || (fn[2:1] == 2'b11);
      OP_STORE:  is_illegal = fn[2] || (fn[1] && fn[0]);
      OP_BRANCH: is_illegal = (fn[2:1] == 2'b01);
      OP_REG:    is_illegal = (ins[31:25] != 7'b0000000) && (ins[31:25] != 7'b0100000);
      default:   is_illegal = 1'b1;
    endcase
  endfunction
`endif

  always_comb begin
    d_rs1 = ds_i_instr[19:15];
    d_rs2 = ds_i_instr[24:20];
    d_rd  = ds_i_instr[11:7];
    d_imm = '0;
    d_alu = ALU_ADD;
    case (op)
      OP_LUI, OP_AUIPC: begin
        d_rs1 = '0;
        d_imm = {ds_i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        d_rs1 = '0;
        d_imm = {{11{ds_i_instr[31]}}, ds_i_instr[31], ds_i_instr[19:12], ds_i_instr[20],
                 ds_i_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD: d_imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:20]};
      OP_STORE: begin
        d_rd  = '0;
        d_imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:25], ds_i_instr[11:7]};
      end
      OP_BRANCH: begin
        d_rd  = '0;
        d_imm = {{19{ds_i_instr[31]}}, ds_i_instr[31], ds_i_instr[7], ds_i_instr[30:25],
                 ds_i_instr[11:8], 1'b0};
        case (f3)
          3'b000:  d_alu = 4'd10;
          3'b001:  d_alu = 4'd11;
          3'b100:  d_alu = 4'd12;
          3'b101:  d_alu = 4'd13;
          3'b110:  d_alu = 4'd14;
          3'b111:  d_alu = 4'd15;
          default: d_alu = ALU_ADD;
        endcase
      end
      OP_IMM: begin
        d_imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:20]};
        // Only the shift-right encoding gives instr[30] meaning; ADDI with a negative imm must stay ADD.
        d_alu = alu_fn(f3, (f3 == 3'b101) && ds_i_instr[30]);
      end
      OP_REG:  d_alu = alu_fn(f3, ds_i_instr[30]);
      default: d_rd = '0;
    endcase
`ifdef DECODE_ILLEGAL_EN
    d_illegal = is_illegal(ds_i_instr);
    if (d_illegal) begin
      d_rd  = '0;
      d_alu = ALU_ADD;
    end
`endif
  end

  always_comb begin
    use_rs1 = (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
              (op == OP_BRANCH) || (op == OP_REG) || (op == OP_JALR);
    use_rs2 = (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    hazard  = ds_o_ce && (ds_o_opcode == OP_LOAD) && (ds_o_rd_addr != '0) && ds_i_ce &&
              ((use_rs1 && (ds_i_instr[19:15] == ds_o_rd_addr)) ||
               (use_rs2 && (ds_i_instr[24:20] == ds_o_rd_addr))) && !ds_i_flush;
  end

  assign ds_o_stall = ds_i_stall | hazard;
  assign ds_o_flush = ds_i_flush;

  always_ff @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) begin
      ds_o_ce       <= 1'b0;
      ds_o_pc       <= '0;
      ds_o_rs1_addr <= '0;
      ds_o_rs2_addr <= '0;
      ds_o_rd_addr  <= '0;
      ds_o_imm      <= '0;
      ds_o_opcode   <= '0;
      ds_o_funct3   <= '0;
      ds_o_alu_op   <= '0;
    end else if (ds_i_flush) begin
      ds_o_ce <= 1'b0;
    end else if (ds_i_stall) begin
      ds_o_ce <= ds_o_ce;
    end else if (hazard) begin
      ds_o_ce <= 1'b0;
    end else begin
      ds_o_ce <= ds_i_ce;
      if (ds_i_ce) begin
        ds_o_pc       <= ds_i_pc;
        ds_o_rs1_addr <= d_rs1;
        ds_o_rs2_addr <= d_rs2;
        ds_o_rd_addr  <= d_rd;
        ds_o_imm      <= d_imm;
        ds_o_opcode   <= op;
        ds_o_funct3   <= f3;
        ds_o_alu_op   <= d_alu;
      end
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) ds_o_illegal <= 1'b0;
    else if (!ds_i_flush && !ds_i_stall && !hazard && ds_i_ce) ds_o_illegal <= d_illegal;
  end
`else
  assign ds_o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, immediates, ALU codes, load-use bubble, stall/flush and illegal encodings.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc;
  logic        i_ce, i_stall, i_flush;
  logic        o_stall, o_flush, o_ce, o_illegal;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [6:0]  o_opcode;
  logic [2:0]  o_funct3;
  logic [3:0]  o_alu;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_ill;

  decode_stage dut (
    .ds_clk(clk), .ds_rst(rst), .ds_i_instr(instr), .ds_i_pc(pc), .ds_i_ce(i_ce),
    .ds_i_stall(i_stall), .ds_i_flush(i_flush), .ds_o_stall(o_stall), .ds_o_flush(o_flush),
    .ds_o_ce(o_ce), .ds_o_pc(o_pc), .ds_o_rs1_addr(o_rs1), .ds_o_rs2_addr(o_rs2),
    .ds_o_rd_addr(o_rd), .ds_o_imm(o_imm), .ds_o_opcode(o_opcode), .ds_o_funct3(o_funct3),
    .ds_o_alu_op(o_alu), .ds_o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p, input logic ce);
    instr = ins;
    pc    = p;
    i_ce  = ce;
  endtask

  initial begin
`ifdef DECODE_ILLEGAL_EN
    exp_ill = 32'd1;
`else
    exp_ill = 32'd0;
`endif
    rst = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    #2;
    chk("reset_ce", {31'd0, o_ce}, 32'd0);
    chk("reset_pc", o_pc, 32'd0);
    tick(); tick();
    rst = 1'b1;

    // addi x1,x0,5
    drive(32'h00500093, 32'h100, 1'b1);
    tick();
    chk("addi_ce", {31'd0, o_ce}, 32'd1);
    chk("addi_rd", {27'd0, o_rd}, 32'd1);
    chk("addi_rs1", {27'd0, o_rs1}, 32'd0);
    chk("addi_imm", o_imm, 32'd5);
    chk("addi_alu", {28'd0, o_alu}, 32'd0);
    chk("addi_pc", o_pc, 32'h100);
    chk("addi_opcode", {25'd0, o_opcode}, 32'h13);

    // asynchronous reset mid-cycle while valid
    #3 rst = 1'b0;
    #1;
    chk("async_rst_ce", {31'd0, o_ce}, 32'd0);
    chk("async_rst_rd", {27'd0, o_rd}, 32'd0);
    chk("async_rst_imm", o_imm, 32'd0);
    chk("async_rst_pc", o_pc, 32'd0);
    rst = 1'b1;

    drive(32'hFFF00093, 32'h104, 1'b1);
    tick();
    chk("addi_neg_imm", o_imm, 32'hFFFFFFFF);
    chk("addi_neg_alu", {28'd0, o_alu}, 32'd0);

    // beq x1,x2,+8
    drive(32'h00208463, 32'h108, 1'b1);
    tick();
    chk("beq_rs1", {27'd0, o_rs1}, 32'd1);
    chk("beq_rs2", {27'd0, o_rs2}, 32'd2);
    chk("beq_rd", {27'd0, o_rd}, 32'd0);
    chk("beq_imm", o_imm, 32'd8);
    chk("beq_alu", {28'd0, o_alu}, 32'd10);

    // sub x5,x6,x7
    drive(32'h407302B3, 32'h10C, 1'b1);
    tick();
    chk("sub_alu", {28'd0, o_alu}, 32'd1);
    chk("sub_imm", o_imm, 32'd0);
    chk("sub_rd", {27'd0, o_rd}, 32'd5);
    chk("sub_rs2", {27'd0, o_rs2}, 32'd7);

    // srai x1,x2,3
    drive(32'h40315093, 32'h110, 1'b1);
    tick();
    chk("srai_alu", {28'd0, o_alu}, 32'd7);
    chk("srai_imm", o_imm, 32'h403);

    // lui x5,0x12345
    drive(32'h123452B7, 32'h114, 1'b1);
    tick();
    chk("lui_imm", o_imm, 32'h12345000);
    chk("lui_rs1", {27'd0, o_rs1}, 32'd0);
    chk("lui_rd", {27'd0, o_rd}, 32'd5);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h118, 1'b1);
    tick();
    chk("sw_imm", o_imm, 32'd8);
    chk("sw_rd", {27'd0, o_rd}, 32'd0);
    chk("sw_rs1", {27'd0, o_rs1}, 32'd1);

    // jal x1,+16
    drive(32'h010000EF, 32'h11C, 1'b1);
    tick();
    chk("jal_imm", o_imm, 32'd16);
    chk("jal_rd", {27'd0, o_rd}, 32'd1);
    chk("jal_rs1", {27'd0, o_rs1}, 32'd0);

    // lw x2,0(x1) then add x3,x2,x1: one bubble
    drive(32'h0000A103, 32'h120, 1'b1);
    tick();
    chk("lw_rd", {27'd0, o_rd}, 32'd2);
    drive(32'h001101B3, 32'h124, 1'b1);
    #1;
    chk("lu_stall", {31'd0, o_stall}, 32'd1);
    tick();
    chk("lu_bubble_ce", {31'd0, o_ce}, 32'd0);
    chk("lu_bubble_rd_hold", {27'd0, o_rd}, 32'd2);
    chk("lu_stall_clear", {31'd0, o_stall}, 32'd0);
    tick();
    chk("lu_add_ce", {31'd0, o_ce}, 32'd1);
    chk("lu_add_rs1", {27'd0, o_rs1}, 32'd2);
    chk("lu_add_rs2", {27'd0, o_rs2}, 32'd1);
    chk("lu_add_rd", {27'd0, o_rd}, 32'd3);

    // external stall for 3 cycles: add stays in the register
    drive(32'h00500093, 32'h128, 1'b1);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_out", {31'd0, o_stall}, 32'd1);
      tick();
      chk("stall_hold_rd", {27'd0, o_rd}, 32'd3);
      chk("stall_hold_ce", {31'd0, o_ce}, 32'd1);
    end
    i_flush = 1'b1;
    #1;
    chk("flush_out", {31'd0, o_flush}, 32'd1);
    tick();
    chk("flush_ce", {31'd0, o_ce}, 32'd0);
    i_stall = 1'b0; i_flush = 1'b0;

    // load followed by a flushed dependent: hazard suppressed
    drive(32'h0000A103, 32'h200, 1'b1);
    tick();
    drive(32'h001101B3, 32'h204, 1'b1);
    i_flush = 1'b1;
    #1;
    chk("flush_masks_hazard", {31'd0, o_stall}, 32'd0);
    tick();
    i_flush = 1'b0;

    // all-ones encoding: unsupported opcode
    drive(32'hFFFFFFFF, 32'h300, 1'b1);
    tick();
    chk("ill_flag", {31'd0, o_illegal}, exp_ill);
    chk("ill_ce", {31'd0, o_ce}, 32'd1);
    chk("ill_rd", {27'd0, o_rd}, 32'd0);
    chk("ill_alu", {28'd0, o_alu}, 32'd0);

    // legal follow-up clears the flag
    drive(32'h00500093, 32'h304, 1'b1);
    tick();
    chk("legal_clears_ill", {31'd0, o_illegal}, 32'd0);

    drive(32'h0, 32'h0, 1'b0);
    tick();
    chk("idle_ce", {31'd0, o_ce}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
